// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and MIPS encoding constants
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC select: jr > jump > taken branch > sequential
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic        jr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] branch_off;
    logic        unused_opcode;

    assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign misalign      = jr && (rs_data[1:0] != 2'b00);
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC register and IDLE/FETCH/EXEC fetch FSM feeding the decoder
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IM_AW-1:0] im_addr,
    output logic             im_req,
    input  logic [31:0]      im_rdata,
    input  logic             im_ready,
    input  logic             pc_wre,
    input  logic             branch,
    input  logic             jump,
    input  logic             jr,
    input  logic             zero,
    input  logic [31:0]      rs_data,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [5:0]       func,
    output logic [4:0]       rt,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             align_err
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic         misalign;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .rs_data  (rs_data),
        .jr       (jr),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .next_pc  (next_pc),
        .misalign (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            instr     <= 32'd0;
            align_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (im_ready) begin
                        instr <= im_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Without pc_wre the decoder is stalled; instr and pc hold.
                    if (pc_wre) begin
                        pc        <= next_pc;
                        align_err <= align_err | misalign;
                        state     <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign im_req      = (state == ST_FETCH);
    assign instr_valid = (state == ST_EXEC);
    assign im_addr     = pc[IM_AW+1:2];
    assign pc_plus4    = pc + 32'd4;
    assign op          = instr[31:26];
    assign func        = instr[5:0];
    assign rt          = instr[20:16];

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic [9:0]  im_addr;
    logic        im_req;
    logic [31:0] im_rdata;
    logic        im_ready;
    logic        pc_wre;
    logic        branch;
    logic        jump;
    logic        jr;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rt;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        align_err;

    ifetch_unit #(.RESET_PC(RST_PC), .IM_AW(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .im_addr     (im_addr),
        .im_req      (im_req),
        .im_rdata    (im_rdata),
        .im_ready    (im_ready),
        .pc_wre      (pc_wre),
        .branch      (branch),
        .jump        (jump),
        .jr          (jr),
        .zero        (zero),
        .rs_data     (rs_data),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .rt          (rt),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mpc;
    logic        malign;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input logic [31:0] rs, input logic c_jr,
                                               input logic c_j, input logic c_b, input logic c_z);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (c_jr)           return {rs[31:2], 2'b00};
        if (c_j)            return {p4[31:28], ins[25:0], 2'b00};
        if (c_b && c_z)     return p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
        return p4;
    endfunction

    // One instruction: fetch (with wait states), EXEC (with stall), then PC update or mid-EXEC reset.
    task automatic run_instr(input logic [31:0] rdata, input int waits, input int stall,
                             input logic c_jr, input logic c_j, input logic c_b, input logic c_z,
                             input logic [31:0] rs, input bit rst_mid);
        exp_t e;
        int   n;
        n = 0;
        while (!im_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!im_req) begin
            chk("fetch_timeout", 32'(im_req), 32'd1);
            return;
        end
        chk("im_addr", 32'(im_addr), 32'(mpc[11:2]));
        for (int i = 0; i < waits; i++) begin
            im_ready = 1'b0;
            @(negedge clk);
            chk("wait_req", 32'(im_req), 32'd1);
            chk("wait_valid", 32'(instr_valid), 32'd0);
            chk("wait_pc", pc, mpc);
        end
        im_ready = 1'b1;
        im_rdata = rdata;
        sb.push_back('{pc: mpc, instr: rdata});
        @(negedge clk);
        im_ready = 1'b0;
        im_rdata = $urandom;
        chk("valid", 32'(instr_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("instr", instr, e.instr);
        chk("op", 32'(op), 32'(e.instr[31:26]));
        chk("func", 32'(func), 32'(e.instr[5:0]));
        chk("rt", 32'(rt), 32'(e.instr[20:16]));
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        for (int i = 0; i < stall; i++) begin
            pc_wre   = 1'b0;
            im_ready = 1'b1;
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc, e.pc);
            chk("stall_instr", instr, e.instr);
        end
        im_ready = 1'b0;
        if (rst_mid) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            mpc    = RST_PC;
            malign = 1'b0;
            chk("rst_pc", pc, RST_PC);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_req", 32'(im_req), 32'd0);
            chk("rst_instr", instr, 32'd0);
            return;
        end
        jr = c_jr; jump = c_j; branch = c_b; zero = c_z; rs_data = rs;
        pc_wre = 1'b1;
        mpc    = model_next(e.pc, e.instr, rs, c_jr, c_j, c_b, c_z);
        malign = malign | (c_jr && rs[1:0] != 2'b00);
        @(negedge clk);
        jr = 0; jump = 0; branch = 0; zero = 0; pc_wre = 0; rs_data = $urandom;
        chk("next_pc", pc, mpc);
        chk("post_valid", 32'(instr_valid), 32'd0);
        chk("align_err", 32'(align_err), 32'(malign));
    endtask

    initial begin
        rst_n = 0; im_rdata = 0; im_ready = 0; pc_wre = 0;
        branch = 0; jump = 0; jr = 0; zero = 0; rs_data = 0;
        mpc = RST_PC; malign = 0;
        repeat (2) @(negedge clk);
        chk("reset_pc", pc, RST_PC);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_req", 32'(im_req), 32'd0);
        chk("reset_op", 32'(op), 32'd0);
        chk("reset_align", 32'(align_err), 32'd0);
        rst_n = 1;
        @(negedge clk);
        chk("first_fetch_req", 32'(im_req), 32'd1);

        run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("addi_pc", pc, 32'h0000_3004);
        chk("addi_next_req", 32'(im_req), 32'd1);
        chk("addi_next_addr", 32'(im_addr), 32'(10'h001));

        run_instr(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'h0000_3010, 0);
        run_instr(32'h1000_FFFE, 5, 0, 0, 0, 1, 1, 32'h0, 0);
        chk("beq_taken", pc, 32'h0000_300C);
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h1000_FFFE, 0, 0, 0, 0, 1, 0, 32'h0, 0);
        chk("beq_not_taken", pc, 32'h0000_3014);

        run_instr(32'h2129_0001, 0, 4, 0, 0, 0, 0, 0, 1);

        run_instr(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0);
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_addr", 32'(im_addr), 32'd0);

        run_instr(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'h0040_0008, 0);
        run_instr(32'h0810_0000, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        chk("j_target", pc, 32'h0040_0000);
        run_instr(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'h0040_0008, 0);
        run_instr(32'h0810_0000, 0, 0, 1, 1, 0, 0, 32'h0000_5006, 0);
        chk("jr_wins", pc, 32'h0000_5004);
        chk("jr_misalign", 32'(align_err), 32'd1);
        run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("align_sticky", 32'(align_err), 32'd1);

        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("final_rst_align", 32'(align_err), 32'd0);
        chk("final_rst_pc", pc, RST_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS core, directly upstream of the control decoder.
- Owns the PC register and a small fetch FSM that handshakes with instruction memory.
- Presents the held instruction and its op/func/rt fields to the decoder for one execute window.
- Computes next-PC from the decoder's PCWre/Branch/Jump outputs, the ALU zero flag, and the jr/jalr register operand.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_AW, 10, instruction-memory word-address width; im_addr = pc[IM_AW+1:2].

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- im_addr  out  IM_AW  word address to instruction memory
- im_req  out  1  fetch request
- im_rdata  in  32  instruction word; sampled when im_req && im_ready
- im_ready  in  1  memory data valid this cycle
- pc_wre  in  1  PC update enable from the decoder (PCWre)
- branch  in  1  decoder Branch
- jump  in  1  decoder Jump (j)
- jr  in  1  register jump (jr/jalr, decoded from func)
- zero  in  1  ALU branch-condition result
- rs_data  in  32  register-file rs read data (jr target)
- instr  out  32  held instruction
- op  out  6  instr[31:26]
- func  out  6  instr[5:0]
- rt  out  5  instr[20:16]
- instr_valid  out  1  high during the EXEC window
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4 (link value for jalr/jal)
- align_err  out  1  sticky flag: misaligned jr target

Behaviour:
- Reset (rst_n low at a clock edge): pc=RESET_PC, state=IDLE, instr=0, instr_valid=0, im_req=0, align_err=0.
- Reset while state is FETCH or EXEC aborts the operation; any im_ready in that cycle is ignored.
- FSM states: IDLE, FETCH, EXEC.
  - IDLE -> FETCH unconditionally after one cycle.
  - FETCH: im_req=1 and im_addr=pc[IM_AW+1:2], both combinational from the state. When im_ready=1, instr<=im_rdata and the FSM goes to EXEC. Otherwise it stays in FETCH; wait states are unbounded.
  - EXEC: instr_valid=1 and im_req=0. If pc_wre=1: pc<=next_pc and the FSM goes to FETCH. If pc_wre=0: it stays in EXEC, instr and pc hold, and instr_valid stays high (stall/halt).
- Throughput is 2 cycles per instruction with zero-wait memory; the first instr_valid appears 3 cycles after reset release.
- next_pc is combinational and evaluated in EXEC. Priority is jr > jump > branch > sequential:
  - jr: {rs_data[31:2], 2'b00}. align_err<=1 if rs_data[1:0]!=0 at the update edge.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch && zero: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}, modulo 2^32.
  - otherwise: pc_plus4.
- pc_plus4 = pc + 32'd4 and wraps 32'hFFFF_FFFC -> 32'h0000_0000 without any flag.
- branch with zero=0 takes the sequential path.
- align_err clears only on reset.
- op/func/rt are pure slices of instr and read 0 after reset.
- An im_ready pulse outside FETCH is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - the fetch state enum (IDLE/FETCH/EXEC);
  - RESET_PC default;
  - opcode constants OP_RTYPE 6'b000000, OP_J 6'b000010;
  - func constants FN_JR 6'b001000, FN_JALR 6'b001001.
- One combinational sub-module, next_pc_calc: inputs pc_plus4, instr, rs_data, jr, jump, branch, zero; outputs next_pc and misalign. The FSM and PC register stay in ifetch_unit.

Test Plan:
- Reset, then im_ready held 1 with im_rdata=32'h2008_0005 (addi) and pc_wre=1 -> im_addr=0x3000>>2, then instr_valid for 1 cycle with op=6'b001000, then pc=0x3004, then the next fetch at 0x3004.
- In EXEC at pc=0x3010: branch=1, zero=1, instr[15:0]=16'hFFFE, pc_wre=1 -> pc=0x300C. Same stimulus with zero=0 -> pc=0x3014.
- In EXEC at pc=0x0040_0008: jump=1, instr[25:0]=26'h010_0000 -> pc=0x0040_0000. Same edge with jr=1, rs_data=0x0000_5006 -> pc=0x0000_5004 (jr wins) and align_err=1, which stays 1 until reset.
- im_ready held low for 5 cycles in FETCH -> im_req held high, instr_valid=0, pc unchanged; im_ready pulse on cycle 6 -> EXEC on the next cycle with instr = im_rdata from that cycle.
- pc_wre=0 in EXEC for 4 cycles -> instr_valid stays 1 and pc/instr are stable; rst_n low for one edge mid-EXEC -> pc=RESET_PC, instr_valid=0, state IDLE.
- pc=32'hFFFF_FFFC, sequential instruction, pc_wre=1 -> pc_plus4=0, next fetch at address 0.
